// File: rtl/meas_point_fifo.sv
// meas_point_fifo: Wishbone-readable FIFO of measurement points {ch, delay code, DAC code}.
// Define MEAS_POINT_FIFO_OVF_CNT_EN to add the saturating dropped-point counter at index 2.
module meas_point_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_adr_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  input  logic        point_rdy_i,
  input  logic [15:0] point_v_i,
  input  logic [9:0]  point_t_i,
  input  logic        point_ch_i,
  output logic        fifo_nempty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 9;
  localparam int unsigned EW = 27;
  localparam int unsigned IW = 3;
  localparam logic [IW-1:0] IDX_DATA   = IW'(0);
  localparam logic [IW-1:0] IDX_STATUS = IW'(1);
  localparam logic [IW-1:0] IDX_OVF    = IW'(2);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ack_q, ack_d;
  logic          nempty_q, nempty_d;
  logic [31:0]   dat_q, dat_d;

  logic          req, rd_req, wr_req, empty, full;
  logic          pop, push, drop, stat_wr, flush, ovf_clr;
  logic [IW-1:0] idx;
  logic [EW-1:0] head;
  logic [31:0]   rdata, ovf_rdata;

  logic unused_c;
  assign unused_c = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:3], wb_dat_i[1]};

  // Decode: every request is acked one cycle later, so effects happen on the edge that raises ack.
  always_comb begin
    req     = wb_cyc_i & wb_stb_i & ~ack_q;
    rd_req  = req & ~wb_we_i;
    wr_req  = req & wb_we_i;
    idx     = wb_adr_i[4:2];
    empty   = (count_q == CW'(0));
    full    = (count_q == CW'(DEPTH));
    head    = mem_q[rd_ptr_q];
    pop     = rd_req & (idx == IDX_DATA) & ~empty;
    stat_wr = wr_req & (idx == IDX_STATUS) & wb_sel_i[0];
    flush   = stat_wr & wb_dat_i[0];
    ovf_clr = stat_wr & wb_dat_i[2];
    // A same-edge pop frees the slot, so a full FIFO only drops when nothing leaves.
    push    = point_rdy_i & ~flush & (~full | pop);
    drop    = point_rdy_i & ~flush & full & ~pop;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_DATA:   rdata = empty ? 32'h0 : {head[26], 1'b1, 4'b0, head[25:0]};
      IDX_STATUS: rdata = {7'b0, count_q, 13'b0, ovf_q, full, empty};
      IDX_OVF:    rdata = ovf_rdata;
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = req;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    dat_d    = dat_q;
    ovf_d    = (ovf_q & ~ovf_clr) | drop;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
    if (rd_req)      dat_d = rdata;
    else if (wr_req) dat_d = '0;
    nempty_d = (count_d != CW'(0));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      nempty_q <= 1'b0;
      dat_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      nempty_q <= nempty_d;
      dat_q    <= dat_d;
    end
  end

  // Storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {point_ch_i, point_t_i, point_v_i};
  end

`ifdef MEAS_POINT_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Clear is applied first so a drop on the same edge still counts.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_req && (idx == IDX_OVF)) ovf_cnt_d = '0;
    if (drop && (ovf_cnt_d != 16'hFFFF)) ovf_cnt_d = ovf_cnt_d + 16'd1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) ovf_cnt_q <= '0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_rdata = {16'h0, ovf_cnt_q};
`else
  assign ovf_rdata = '0;
`endif

  assign wb_dat_o      = dat_q;
  assign wb_ack_o      = ack_q;
  assign fifo_nempty_o = nempty_q;

endmodule

// File: doc/meas_point_fifo.md
MEAS_POINT_FIFO -- requirements
Module: meas_point_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entry count (power of two, 2..256).
REQ-002 The block SHALL have port wb_clk_i  input  1  the single clock for all logic.
REQ-003 The block SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have Wishbone slave ports wb_dat_i in 32, wb_dat_o out 32, wb_adr_i in 32, wb_we_i in 1, wb_sel_i in 4, wb_cyc_i in 1, wb_stb_i in 1, wb_ack_o out 1.
REQ-005 The block SHALL have port point_rdy_i  input  1  single-cycle pulse: point valid from the channel measurement controller.
REQ-006 The block SHALL have port point_v_i  input  16  threshold DAC code of the point.
REQ-007 The block SHALL have port point_t_i  input  10  delay-line code of the point.
REQ-008 The block SHALL have port point_ch_i  input  1  channel tag (0 = ch 1, 1 = ch 2).
REQ-009 The block SHALL have port fifo_nempty_o  output  1  high while the FIFO holds one or more entries.

Function
REQ-010 Register index SHALL be wb_adr_i[4:2]: 0 = DATA, 1 = STATUS, 2 = OVF_CNT; other indices read 0, ignore writes.
REQ-011 wb_ack_o SHALL assert the cycle after wb_cyc_i & wb_stb_i with ack low, for exactly one cycle; a held request is therefore acked every second cycle.
REQ-012 Register side effects (pop, clear, flush) SHALL occur only on the cycle wb_ack_o is set, once per ack.
REQ-013 DATA read SHALL return {ch[31], valid[30], 0[29:26], t[25:16], v[15:0]} of the head entry and pop it; when empty it SHALL return 0 (valid = 0) and leave pointers unchanged.
REQ-014 DATA writes SHALL be ignored.
REQ-015 STATUS read SHALL return {0[31:25], count[24:16], 0[15:3], ovf[2], full[1], empty[0]}; count is 9 bits, 0..DEPTH.
REQ-016 STATUS write SHALL use byte-lane 0 only: bit 0 = 1 flushes (pointers, count to 0); bit 2 = 1 clears ovf (W1C); wb_sel_i[0] = 0 makes the write a no-op.
REQ-017 A point_rdy_i pulse SHALL push {point_ch_i, point_t_i, point_v_i} at that clock edge when not full; count rises the next cycle.
REQ-018 A push while full and no pop on the same edge SHALL drop the point and set ovf sticky.
REQ-019 Push and pop on the same edge SHALL both complete; count unchanged; when full no drop occurs.
REQ-020 Push and pop on the same edge while empty: pop returns valid = 0, push is stored, count becomes 1.
REQ-021 Flush and push on the same edge: flush wins, point discarded, ovf and OVF_CNT unchanged.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 fifo_nempty_o SHALL be registered and equal ~empty as of the current cycle.

Reset
REQ-024 On wb_rst_i: pointers, count, ovf, OVF_CNT, wb_ack_o, wb_dat_o = 0; fifo_nempty_o = 0; storage contents undefined.
REQ-025 Reset asserted mid-transaction SHALL abort it with no ack, and after release the FIFO SHALL be empty.

Configuration
REQ-026 With macro MEAS_POINT_FIFO_OVF_CNT_EN defined, OVF_CNT SHALL be a 16-bit count of dropped points, saturating at 16'hFFFF, cleared by any acked write to index 2.
REQ-027 Without MEAS_POINT_FIFO_OVF_CNT_EN, index 2 SHALL read 0, ignore writes and instantiate no counter; ovf behaviour is unchanged.

Verification
REQ-028 Push 3 points (v=0x0010/t=0x005/ch0, 0x0020/0x006/ch1, 0x0030/0x007/ch0), read DATA x3 -> 0x40050010, 0xC0060020, 0x40070030, then STATUS = 0x00000001.
REQ-029 DEPTH=16: push 18 points -> STATUS = 0x00100006; OVF_CNT = 2 (macro on), 0 (macro off); write STATUS 0x4 -> ovf = 0, count still 16.
REQ-030 Full FIFO: push and DATA-read ack on the same edge -> count stays 16, ovf stays 0, returned entry = oldest.
REQ-031 Write STATUS 0x1 with point_rdy_i on the same edge, 5 entries held -> STATUS = 0x00000001, fifo_nempty_o = 0, ovf = 0.
REQ-032 Empty FIFO: DATA read -> 0x00000000; 20 push/pop cycles across the pointer wrap -> data order preserved.
REQ-033 wb_rst_i pulsed with 7 entries while wb_cyc_i & wb_stb_i held -> no ack during reset; after release STATUS = 0x00000001.
